// File: rtl/ap_pass_sequencer.sv
// Sequencer in front of the CAM array: runs bit-serial compare/parallel-write passes
// and shares the array with a host addressed-write/read port.
module ap_pass_sequencer #(
  parameter int WORD_SIZE  = 8,
  parameter int CELL_QUANT = 512,
  parameter int ADDR_W     = $clog2(CELL_QUANT + 1),
  parameter int ITER_W     = $clog2(WORD_SIZE + 1)
) (
  input  logic                  CLK100MHZ,
  input  logic                  rst,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [WORD_SIZE-1:0]  cmd_key,
  input  logic [WORD_SIZE-1:0]  cmd_mask,
  input  logic [WORD_SIZE-1:0]  cmd_wdata,
  input  logic [ITER_W-1:0]     cmd_iters,
  input  logic                  host_wr_valid,
  output logic                  host_wr_ready,
  input  logic [ADDR_W-1:0]     host_wr_addr,
  input  logic [WORD_SIZE-1:0]  host_wr_data,
  input  logic [ADDR_W-1:0]     host_rd_addr,
  output logic                  cam_mode,
  output logic [ADDR_W-1:0]     cam_addr,
  output logic                  cam_wea,
  output logic [WORD_SIZE-1:0]  cam_dina,
  output logic [WORD_SIZE-1:0]  cam_key,
  output logic [WORD_SIZE-1:0]  cam_mask,
  output logic [CELL_QUANT-1:0] cam_wea_ap,
  input  logic [CELL_QUANT-1:0] cam_tags,
  output logic                  busy,
  output logic                  done,
  output logic                  any_match
);

  typedef enum logic [2:0] {
    ST_IDLE, ST_H_WR, ST_H_HOLD, ST_CMP, ST_CAP, ST_WR, ST_SETTLE, ST_DONE
  } state_t;

  state_t                state_q, state_d;
  logic [ADDR_W-1:0]     addr_q, addr_d;
  logic [WORD_SIZE-1:0]  hdata_q, hdata_d;
  logic [WORD_SIZE-1:0]  key_q, key_d;
  logic [WORD_SIZE-1:0]  mask_q, mask_d;
  logic [WORD_SIZE-1:0]  wdata_q, wdata_d;
  logic [ITER_W-1:0]     iters_q, iters_d;
  logic [ITER_W-1:0]     i_q, i_d;
  logic [CELL_QUANT-1:0] tag_q, tag_d;
  logic                  any_match_q, any_match_d;

  logic                  cam_mode_q, cam_mode_d;
  logic                  cam_wea_q, cam_wea_d;
  logic [WORD_SIZE-1:0]  cam_dina_q, cam_dina_d;
  logic [WORD_SIZE-1:0]  cam_key_q, cam_key_d;
  logic [WORD_SIZE-1:0]  cam_mask_q, cam_mask_d;
  logic [CELL_QUANT-1:0] cam_wea_ap_q, cam_wea_ap_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;

  logic [ITER_W:0]       next_i;
  logic                  pass_active;

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    hdata_d     = hdata_q;
    key_d       = key_q;
    mask_d      = mask_q;
    wdata_d     = wdata_q;
    iters_d     = iters_q;
    i_d         = i_q;
    tag_d       = tag_q;
    any_match_d = any_match_q;
    next_i      = {1'b0, i_q} + {{ITER_W{1'b0}}, 1'b1};

    case (state_q)
      ST_IDLE: begin
        if (host_wr_valid) begin
          state_d = ST_H_WR;
          addr_d  = host_wr_addr;
          hdata_d = host_wr_data;
        end else if (cmd_valid) begin
          state_d     = ST_CMP;
          key_d       = cmd_key;
          mask_d      = cmd_mask;
          wdata_d     = cmd_wdata;
          iters_d     = (cmd_iters == '0) ? {{(ITER_W-1){1'b0}}, 1'b1} : cmd_iters;
          i_d         = '0;
          any_match_d = 1'b0;
        end
      end
      ST_H_WR:   state_d = ST_H_HOLD;
      ST_H_HOLD: state_d = ST_IDLE;
      ST_CMP:    state_d = ST_CAP;
      ST_CAP: begin
        state_d     = ST_WR;
        tag_d       = cam_tags;
        any_match_d = any_match_q | (|cam_tags);
      end
      ST_WR:     state_d = ST_SETTLE;
      ST_SETTLE: begin
        if (next_i < {1'b0, iters_q}) begin
          i_d     = next_i[ITER_W-1:0];
          state_d = ST_CMP;
        end else begin
          state_d = ST_DONE;
        end
      end
      ST_DONE:   state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase

    // Outputs are decoded from the state being entered so they register alongside it
    pass_active  = (state_d == ST_CMP) || (state_d == ST_CAP) ||
                   (state_d == ST_WR)  || (state_d == ST_SETTLE);
    cam_mode_d   = pass_active;
    cam_wea_d    = (state_d == ST_H_WR);
    cam_wea_ap_d = (state_d == ST_WR) ? tag_d : '0;
    cam_key_d    = pass_active ? (key_d << i_d)  : '0;
    cam_mask_d   = pass_active ? (mask_d << i_d) : '0;
    if ((state_d == ST_H_WR) || (state_d == ST_H_HOLD)) begin
      cam_dina_d = hdata_d;
    end else if (pass_active) begin
      cam_dina_d = wdata_d;
    end else begin
      cam_dina_d = '0;
    end
    busy_d = (state_d != ST_IDLE);
    done_d = (state_d == ST_DONE);
  end

  always_ff @(posedge CLK100MHZ) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      addr_q       <= '0;
      hdata_q      <= '0;
      key_q        <= '0;
      mask_q       <= '0;
      wdata_q      <= '0;
      iters_q      <= '0;
      i_q          <= '0;
      tag_q        <= '0;
      any_match_q  <= 1'b0;
      cam_mode_q   <= 1'b0;
      cam_wea_q    <= 1'b0;
      cam_dina_q   <= '0;
      cam_key_q    <= '0;
      cam_mask_q   <= '0;
      cam_wea_ap_q <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      hdata_q      <= hdata_d;
      key_q        <= key_d;
      mask_q       <= mask_d;
      wdata_q      <= wdata_d;
      iters_q      <= iters_d;
      i_q          <= i_d;
      tag_q        <= tag_d;
      any_match_q  <= any_match_d;
      cam_mode_q   <= cam_mode_d;
      cam_wea_q    <= cam_wea_d;
      cam_dina_q   <= cam_dina_d;
      cam_key_q    <= cam_key_d;
      cam_mask_q   <= cam_mask_d;
      cam_wea_ap_q <= cam_wea_ap_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
    end
  end

  // The read port owns the address bus whenever the array is idle
  assign cam_addr      = (state_q == ST_IDLE) ? host_rd_addr : addr_q;
  assign cmd_ready     = (state_q == ST_IDLE) && !host_wr_valid;
  assign host_wr_ready = (state_q == ST_IDLE);
  assign cam_mode      = cam_mode_q;
  assign cam_wea       = cam_wea_q;
  assign cam_dina      = cam_dina_q;
  assign cam_key       = cam_key_q;
  assign cam_mask      = cam_mask_q;
  assign cam_wea_ap    = cam_wea_ap_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign any_match     = any_match_q;

endmodule

// File: tb/tb_ap_pass_sequencer.sv
// Scoreboard bench for ap_pass_sequencer with a behavioural 512x8 CAM model.
module tb_ap_pass_sequencer;

  localparam int WS = 8;
  localparam int CQ = 512;
  localparam int AW = 10;
  localparam int IW = 4;

  typedef struct packed { logic [7:0] key; logic [7:0] mask; } key_exp_t;
  typedef struct packed { logic [9:0] addr; logic [7:0] data; } hw_exp_t;
  typedef struct { int lat; logic match; } done_exp_t;

  logic          CLK100MHZ = 1'b0;
  logic          rst;
  logic          cmd_valid, cmd_ready;
  logic [WS-1:0] cmd_key, cmd_mask, cmd_wdata;
  logic [IW-1:0] cmd_iters;
  logic          host_wr_valid, host_wr_ready;
  logic [AW-1:0] host_wr_addr, host_rd_addr;
  logic [WS-1:0] host_wr_data;
  logic          cam_mode, cam_wea;
  logic [AW-1:0] cam_addr;
  logic [WS-1:0] cam_dina, cam_key, cam_mask;
  logic [CQ-1:0] cam_wea_ap, cam_tags;
  logic          busy, done, any_match;

  logic                mem_clear;
  logic [CQ-1:0][7:0]  mem, mem_n;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int acc_edge = 0;
  int done_seen = 0;

  key_exp_t    key_q[$];
  logic [511:0] ap_q[$];
  done_exp_t   done_q[$];
  hw_exp_t     hw_q[$];

  ap_pass_sequencer #(.WORD_SIZE(WS), .CELL_QUANT(CQ)) dut (
    .CLK100MHZ(CLK100MHZ), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_key(cmd_key), .cmd_mask(cmd_mask), .cmd_wdata(cmd_wdata), .cmd_iters(cmd_iters),
    .host_wr_valid(host_wr_valid), .host_wr_ready(host_wr_ready),
    .host_wr_addr(host_wr_addr), .host_wr_data(host_wr_data), .host_rd_addr(host_rd_addr),
    .cam_mode(cam_mode), .cam_addr(cam_addr), .cam_wea(cam_wea), .cam_dina(cam_dina),
    .cam_key(cam_key), .cam_mask(cam_mask), .cam_wea_ap(cam_wea_ap), .cam_tags(cam_tags),
    .busy(busy), .done(done), .any_match(any_match)
  );

  initial forever #5 CLK100MHZ = ~CLK100MHZ;

  always_ff @(posedge CLK100MHZ) cyc <= cyc + 1;

  // CAM model: a cell matches when it equals the key on every masked bit
  always_comb begin
    cam_tags = '0;
    for (int k = 0; k < CQ; k++) cam_tags[k] = (((mem[k] ^ cam_key) & cam_mask) == 8'h00);
  end

  always_comb begin
    mem_n = mem;
    if (mem_clear) begin
      mem_n = '0;
    end else if (cam_mode) begin
      for (int k = 0; k < CQ; k++) if (cam_wea_ap[k]) mem_n[k] = cam_dina;
    end else if (cam_wea) begin
      mem_n[cam_addr[8:0]] = cam_dina;
    end
  end

  always_ff @(posedge CLK100MHZ) mem <= mem_n;

  task automatic checkOutput(input string name, input logic [511:0] got, input logic [511:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic expect_pass(input logic [7:0] key, input logic [7:0] mask, input logic [511:0] ap);
    key_q.push_back('{key: key, mask: mask});
    ap_q.push_back(ap);
  endtask

  task automatic expect_done(input int lat, input logic match);
    done_exp_t d;
    d.lat = lat;
    d.match = match;
    done_q.push_back(d);
  endtask

  // Monitor: phase 0 of each mode-1 run of four cycles is CMP, phase 2 is WR
  initial begin
    int        cnt;
    int        phase;
    key_exp_t  mk;
    hw_exp_t   mh;
    done_exp_t md;
    logic [511:0] ma;
    cnt = 0;
    mk = '0;
    forever begin
      @(negedge CLK100MHZ);
      if (cmd_valid && cmd_ready) acc_edge = cyc + 1;
      if (cam_wea) begin
        if (hw_q.size() == 0) begin
          checkOutput("hw_unexpected_wea", 512'(cam_wea), 512'(0));
        end else begin
          mh = hw_q.pop_front();
          checkOutput("hw_addr", 512'(cam_addr), 512'(mh.addr));
          checkOutput("hw_data", 512'(cam_dina), 512'(mh.data));
          checkOutput("hw_mode", 512'(cam_mode), 512'(0));
        end
      end
      if (cam_mode) begin
        phase = cnt % 4;
        cnt++;
        if (phase == 0) begin
          if (key_q.size() == 0) begin
            checkOutput("cmp_unexpected", 512'(cam_mode), 512'(0));
          end else begin
            mk = key_q.pop_front();
            checkOutput("cmp_key", 512'(cam_key), 512'(mk.key));
            checkOutput("cmp_mask", 512'(cam_mask), 512'(mk.mask));
          end
        end else begin
          checkOutput("key_held", 512'(cam_key), 512'(mk.key));
          checkOutput("mask_held", 512'(cam_mask), 512'(mk.mask));
        end
        if (phase == 2) begin
          if (ap_q.size() == 0) begin
            checkOutput("wr_unexpected", 512'(cam_mode), 512'(0));
          end else begin
            ma = ap_q.pop_front();
            checkOutput("wr_wea_ap", cam_wea_ap, ma);
          end
        end else begin
          checkOutput("wea_ap_zero", cam_wea_ap, 512'(0));
        end
      end else begin
        cnt = 0;
        checkOutput("wea_ap_zero_idle", cam_wea_ap, 512'(0));
      end
      if (done) begin
        done_seen++;
        if (done_q.size() == 0) begin
          checkOutput("done_unexpected", 512'(done), 512'(0));
        end else begin
          md = done_q.pop_front();
          checkOutput("done_latency", 512'(cyc - acc_edge + 1), 512'(md.lat));
          checkOutput("done_any_match", 512'(any_match), 512'(md.match));
        end
      end
    end
  end

  task automatic host_write(input logic [9:0] addr, input logic [7:0] data);
    int n;
    hw_q.push_back('{addr: addr, data: data});
    host_wr_addr = addr;
    host_wr_data = data;
    host_wr_valid = 1'b1;
    n = 0;
    @(negedge CLK100MHZ);
    while (!host_wr_ready && n < 50) begin n++; @(negedge CLK100MHZ); end
    @(posedge CLK100MHZ);
    #1 host_wr_valid = 1'b0;
    n = 0;
    @(negedge CLK100MHZ);
    while (!host_wr_ready && n < 50) begin n++; @(negedge CLK100MHZ); end
    checkOutput("hw_ready_low_cycles", 512'(n), 512'(2));
    @(posedge CLK100MHZ);
    #1;
  endtask

  task automatic applyStimulus(input logic [7:0] key, input logic [7:0] mask,
                               input logic [7:0] wdata, input logic [3:0] iters);
    int n;
    cmd_key = key;
    cmd_mask = mask;
    cmd_wdata = wdata;
    cmd_iters = iters;
    cmd_valid = 1'b1;
    n = 0;
    @(negedge CLK100MHZ);
    while (!cmd_ready && n < 50) begin n++; @(negedge CLK100MHZ); end
    @(posedge CLK100MHZ);
    #1 cmd_valid = 1'b0;
    n = 0;
    @(negedge CLK100MHZ);
    while (busy && n < 200) begin n++; @(negedge CLK100MHZ); end
    checkOutput("cmd_completes", 512'(busy), 512'(0));
    @(posedge CLK100MHZ);
    #1;
  endtask

  task automatic read_check(input string name, input logic [9:0] addr, input logic [7:0] exp);
    host_rd_addr = addr;
    @(negedge CLK100MHZ);
    checkOutput({name, "_addr"}, 512'(cam_addr), 512'(addr));
    checkOutput(name, 512'(mem[cam_addr[8:0]]), 512'(exp));
    @(posedge CLK100MHZ);
    #1;
  endtask

  task automatic check_reset_values(input string pfx);
    checkOutput({pfx, "_mode"}, 512'(cam_mode), 512'(0));
    checkOutput({pfx, "_wea"}, 512'(cam_wea), 512'(0));
    checkOutput({pfx, "_wea_ap"}, cam_wea_ap, 512'(0));
    checkOutput({pfx, "_key"}, 512'(cam_key), 512'(0));
    checkOutput({pfx, "_mask"}, 512'(cam_mask), 512'(0));
    checkOutput({pfx, "_dina"}, 512'(cam_dina), 512'(0));
    checkOutput({pfx, "_addr"}, 512'(cam_addr), 512'(host_rd_addr));
    checkOutput({pfx, "_busy"}, 512'(busy), 512'(0));
    checkOutput({pfx, "_done"}, 512'(done), 512'(0));
    checkOutput({pfx, "_any_match"}, 512'(any_match), 512'(0));
    checkOutput({pfx, "_cmd_ready"}, 512'(cmd_ready), 512'(1));
    checkOutput({pfx, "_host_ready"}, 512'(host_wr_ready), 512'(1));
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int w;
    int seen;
    rst = 1'b1;
    mem_clear = 1'b1;
    cmd_valid = 1'b0;
    cmd_key = '0;
    cmd_mask = '0;
    cmd_wdata = '0;
    cmd_iters = '0;
    host_wr_valid = 1'b0;
    host_wr_addr = '0;
    host_wr_data = '0;
    host_rd_addr = 10'h155;
    repeat (3) @(posedge CLK100MHZ);
    #1 rst = 1'b0;
    mem_clear = 1'b0;
    @(negedge CLK100MHZ);
    check_reset_values("reset");
    @(posedge CLK100MHZ);
    #1;

    $display("[TB] host write and readback");
    host_write(10'd5, 8'hA3);
    read_check("rd_cell5", 10'd5, 8'hA3);
    host_write(10'd0, 8'h01);
    host_write(10'd1, 8'h11);
    host_write(10'd2, 8'h01);

    $display("[TB] single pass");
    expect_pass(8'h01, 8'h0F, 512'h7);
    expect_done(5, 1'b1);
    applyStimulus(8'h01, 8'h0F, 8'hFF, 4'd1);
    checkOutput("single_any_match", 512'(any_match), 512'(1));
    read_check("rd_cell0_ff", 10'd0, 8'hFF);
    read_check("rd_cell1_ff", 10'd1, 8'hFF);
    read_check("rd_cell2_ff", 10'd2, 8'hFF);
    read_check("rd_cell3_00", 10'd3, 8'h00);

    $display("[TB] multi-pass shift");
    expect_pass(8'h01, 8'h01, 512'h27);
    expect_pass(8'h02, 8'h02, 512'h0);
    expect_pass(8'h04, 8'h04, 512'h27);
    expect_done(13, 1'b1);
    applyStimulus(8'h01, 8'h01, 8'h3C, 4'd3);
    read_check("rd_cell0_3c", 10'd0, 8'h3C);
    read_check("rd_cell5_3c", 10'd5, 8'h3C);
    read_check("rd_cell3_still0", 10'd3, 8'h00);

    $display("[TB] no match, iters 0 and 1");
    expect_pass(8'h01, 8'h03, 512'h0);
    expect_done(5, 1'b0);
    applyStimulus(8'h01, 8'h03, 8'hEE, 4'd0);
    checkOutput("nomatch0_any_match", 512'(any_match), 512'(0));
    expect_pass(8'h01, 8'h03, 512'h0);
    expect_done(5, 1'b0);
    applyStimulus(8'h01, 8'h03, 8'hEE, 4'd1);
    checkOutput("nomatch1_any_match", 512'(any_match), 512'(0));

    $display("[TB] arbitration and hold-off");
    hw_q.push_back('{addr: 10'd7, data: 8'h55});
    expect_pass(8'h55, 8'hFF, 512'h80);
    expect_done(5, 1'b1);
    hw_q.push_back('{addr: 10'd9, data: 8'h66});
    host_wr_addr = 10'd7;
    host_wr_data = 8'h55;
    host_wr_valid = 1'b1;
    cmd_key = 8'h55;
    cmd_mask = 8'hFF;
    cmd_wdata = 8'hAA;
    cmd_iters = 4'd1;
    cmd_valid = 1'b1;
    @(negedge CLK100MHZ);
    checkOutput("arb_cmd_ready_low", 512'(cmd_ready), 512'(0));
    checkOutput("arb_host_ready", 512'(host_wr_ready), 512'(1));
    @(posedge CLK100MHZ);
    #1 host_wr_valid = 1'b0;
    @(negedge CLK100MHZ);
    checkOutput("arb_hwr_cmd_ready", 512'(cmd_ready), 512'(0));
    @(negedge CLK100MHZ);
    checkOutput("arb_hhold_cmd_ready", 512'(cmd_ready), 512'(0));
    @(negedge CLK100MHZ);
    checkOutput("arb_idle_cmd_ready", 512'(cmd_ready), 512'(1));
    @(posedge CLK100MHZ);
    #1 cmd_valid = 1'b0;
    host_wr_addr = 10'd9;
    host_wr_data = 8'h66;
    host_wr_valid = 1'b1;
    w = 0;
    @(negedge CLK100MHZ);
    while (!host_wr_ready && w < 50) begin w++; @(negedge CLK100MHZ); end
    checkOutput("holdoff_wait_cycles", 512'(w), 512'(5));
    @(posedge CLK100MHZ);
    #1 host_wr_valid = 1'b0;
    repeat (3) @(posedge CLK100MHZ);
    #1;
    read_check("rd_cell7_aa", 10'd7, 8'hAA);
    read_check("rd_cell9_66", 10'd9, 8'h66);

    $display("[TB] reset during WR of pass 2");
    expect_pass(8'h01, 8'h01, 512'h0);
    expect_pass(8'h02, 8'h02, 512'h280);
    cmd_key = 8'h01;
    cmd_mask = 8'h01;
    cmd_wdata = 8'h3C;
    cmd_iters = 4'd3;
    cmd_valid = 1'b1;
    w = 0;
    @(negedge CLK100MHZ);
    while (!cmd_ready && w < 50) begin w++; @(negedge CLK100MHZ); end
    @(posedge CLK100MHZ);
    #1 cmd_valid = 1'b0;
    repeat (6) @(posedge CLK100MHZ);
    #1 rst = 1'b1;
    @(posedge CLK100MHZ);
    #1 rst = 1'b0;
    seen = done_seen;
    @(negedge CLK100MHZ);
    check_reset_values("midrst");
    repeat (16) @(negedge CLK100MHZ);
    checkOutput("midrst_no_done", 512'(done_seen), 512'(seen));

    checkOutput("left_key_exp", 512'(key_q.size()), 512'(0));
    checkOutput("left_ap_exp", 512'(ap_q.size()), 512'(0));
    checkOutput("left_done_exp", 512'(done_q.size()), 512'(0));
    checkOutput("left_hw_exp", 512'(hw_q.size()), 512'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ap_pass_sequencer.md
Name: ap_pass_sequencer

Overview:
- Control block in front of the CAM array; sequences associative compare-then-parallel-write passes and shares the array with a host single-word write/read port.
- A command (key, mask, write data, iteration count) runs N passes; on each pass the key/mask are shifted left by the pass index, giving bit-serial associative operations.
- Host writes use CAM mode 0 (addressed write). Passes use CAM mode 1 (tag-guided parallel write).

Parameters:
- WORD_SIZE, 8, CAM word width.
- CELL_QUANT, 512, number of CAM cells and the width of the tag vector.
- ADDR_W, clogb2(CELL_QUANT), width of the CAM address; equals 10 at the default.
- ITER_W, clogb2(WORD_SIZE), width of the iteration count; equals 4 at the default.

Ports:
- CLK100MHZ  in  1  system clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- cmd_valid  in  1  pass command request.
- cmd_ready  out  1  high only in IDLE when host_wr_valid=0.
- cmd_key  in  WORD_SIZE  compare key for pass 0.
- cmd_mask  in  WORD_SIZE  compare mask for pass 0.
- cmd_wdata  in  WORD_SIZE  word written to every tagged cell.
- cmd_iters  in  ITER_W  number of passes; 0 is treated as 1.
- host_wr_valid  in  1  addressed write request.
- host_wr_ready  out  1  high when in IDLE.
- host_wr_addr  in  ADDR_W  addressed write target.
- host_wr_data  in  WORD_SIZE  addressed write data.
- host_rd_addr  in  ADDR_W  read address, driven onto cam_addr while in IDLE.
- cam_mode  out  1  0 = addressed write, 1 = tag-guided write.
- cam_addr  out  ADDR_W  CAM address.
- cam_wea  out  1  addressed write enable.
- cam_dina  out  WORD_SIZE  CAM write data.
- cam_key  out  WORD_SIZE  CAM compare key.
- cam_mask  out  WORD_SIZE  CAM compare mask.
- cam_wea_ap  out  CELL_QUANT  parallel write-enable vector.
- cam_tags  in  CELL_QUANT  asynchronous match vector from the CAM.
- busy  out  1  high in any state other than IDLE.
- done  out  1  one-cycle pulse when a command completes.
- any_match  out  1  sticky per command: some pass matched at least one cell.

Behaviour:
- Reset, and the IDLE output values:
  - cam_mode=0, cam_wea=0, cam_wea_ap=0, cam_key=0, cam_mask=0, cam_dina=0.
  - cam_addr=host_rd_addr.
  - busy=0, done=0, any_match=0, pass counter=0.
- States: IDLE, H_WR, H_HOLD, CMP, CAP, WR, SETTLE, DONE.
- IDLE arbitration:
  - host_wr_valid has priority: go to H_WR and latch addr/data.
  - Otherwise, on cmd_valid&&cmd_ready: go to CMP; latch key, mask, wdata and iters (0 becomes 1); clear the pass counter i and any_match.
- H_WR (1 cycle): cam_mode=0, cam_wea=1, cam_addr/cam_dina = latched values. Next state H_HOLD.
- H_HOLD (1 cycle): cam_wea=0; addr/dina held while the CAM's registered one-hot enable fires. Next state IDLE. Host write total: 2 cycles.
- CMP (1 cycle):
  - cam_mode=1, cam_wea_ap=0.
  - cam_key=(key<<i) truncated to WORD_SIZE; cam_mask=(mask<<i) truncated to WORD_SIZE.
- CAP (1 cycle): key/mask held. Register tag_q<=cam_tags. any_match|=|cam_tags.
- WR (1 cycle): cam_wea_ap=tag_q, cam_dina=wdata; key/mask held.
- SETTLE (1 cycle):
  - cam_wea_ap=0, cam_dina held; cells write this cycle.
  - If i+1<iters: i<=i+1, go to CMP. Otherwise go to DONE.
- DONE (1 cycle): done=1, cam_mode returns to 0. Next state IDLE.
- Latency: a command takes 4*iters+1 cycles from the acceptance edge to the done pulse.
- A zero tag vector still runs WR/SETTLE, with no cells written.
- cam_mode=1 is held continuously from CMP through SETTLE of the last pass. This guarantees the CAM's registered enable never sees a stale vector.
- cmd/host requests arriving while busy are not accepted. Ready is low; requests must remain valid.
- any_match holds its value until the next command is accepted.
- rst mid-operation: the next cycle shows IDLE reset values. No done pulse. Any partial pass is abandoned; writes already committed stay.
- Shift wrap: shifted bits beyond WORD_SIZE are discarded, not rotated.

Test Plan:
- Host write: host_wr_valid, addr=5, data=8'hA3 → cam_wea=1 for exactly one cycle with cam_addr=5; host_wr_ready low for 2 cycles; with host_rd_addr=5 afterwards, doutb=8'hA3.
- Single pass: cells 0..3 hold 8'h01,8'h11,8'h01,8'h00; cmd key=8'h01, mask=8'h0F, wdata=8'hFF, iters=1:
  - cam_wea_ap=4'b0111 during WR only.
  - done pulses 5 cycles after acceptance.
  - any_match=1; cells 0,1,2 read 8'hFF and cell 3 reads 8'h00.
- Multi-pass shift: key=8'h01, mask=8'h01, iters=3 → cam_key/cam_mask observed as 01, 02, 04 in successive CMP states; done 13 cycles after acceptance.
- No match, and iters=0: no tag set → cam_wea_ap stays 0 throughout, any_match=0; iters=0 behaves exactly as iters=1.
- Arbitration: host_wr_valid and cmd_valid asserted together in IDLE → host write first, cmd accepted the cycle after H_HOLD; requests raised while busy are held off until IDLE.
- Reset mid-command: assert rst during WR of pass 2 → the next cycle has all outputs at reset values, no done pulse, cmd_ready=1.
